clk_rst_sequencer: RTL and testbench

Start-up and reset sequencer for the Basys3 VGA clocking path. It runs on the free-running 100 MHz board clock and watches the MMCM `locked` flag. It gates the pixel-clock BUFGCE enable only after lock has been stable for a settle period, and drives the functional top's reset. It also debounces the reset button into a soft-reset request, and counts lock-loss events for debug.

---
 rtl/clk_rst_sequencer.sv | 147 ++++++++++++++
 tb/tb_clk_rst_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_sequencer.sv
// Start-up and reset sequencer for the VGA pixel-clock path.
// Waits for a stable MMCM lock, enables the pixel-clock BUFGCE, holds the
// functional reset for a fixed time, and turns a debounced button press
// into a soft reset. Lock losses seen while running are counted for debug.
module clk_rst_sequencer #(
    parameter int SETTLE_CYCLES   = 256,
    parameter int RST_HOLD_CYCLES = 64,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       btn,
    output logic       clk_ce,
    output logic       rst_out,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] SETTLE    = 3'd1;
    localparam logic [2:0] CLK_ON    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    localparam int SET_W = $clog2(SETTLE_CYCLES);
    localparam int HLD_W = $clog2(RST_HOLD_CYCLES);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HOLD_LAST   = HLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

    logic             locked_m, locked_s;
    logic             btn_m, btn_s;
    logic             btn_db, btn_db_q;
    logic [DB_W-1:0]  db_cnt;
    logic             press;
    logic [2:0]       state_r;
    logic [SET_W-1:0] settle_cnt;
    logic [HLD_W-1:0] hold_cnt;

    // Two-flop synchronizers for the asynchronous lock flag and button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
            btn_m    <= btn;
            btn_s    <= btn_m;
        end
    end

    // Debouncer: accept a new button level only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // One-cycle pulse on the accepted 0->1 edge of the button.
    assign press = btn_db & ~btn_db_q;

    // Sequencer FSM; lock loss always wins over counter expiry or a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= WAIT_LOCK;
            settle_cnt    <= '0;
            hold_cnt      <= '0;
            lock_loss_cnt <= '0;
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    settle_cnt <= '0;
                    if (locked_s) state_r <= SETTLE;
                end
                SETTLE: begin
                    if (!locked_s) begin
                        state_r    <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state_r    <= CLK_ON;
                        settle_cnt <= '0;
                        hold_cnt   <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                CLK_ON: begin
                    if (!locked_s) begin
                        state_r  <= FAULT;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_r  <= RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HLD_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_r <= FAULT;
                        if (lock_loss_cnt != 8'hFF)
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                    end else if (press) begin
                        // Soft reset: re-assert rst_out with the clock kept running.
                        state_r  <= CLK_ON;
                        hold_cnt <= '0;
                    end
                end
                FAULT: begin
                    state_r <= WAIT_LOCK;
                end
                default: begin
                    state_r <= WAIT_LOCK;
                end
            endcase
        end
    end

    // Outputs decode from the state register only; unused codes look like WAIT_LOCK.
    assign clk_ce  = (state_r == CLK_ON) || (state_r == RUN);
    assign rst_out = (state_r != RUN);
    assign ready   = (state_r == RUN);
    assign state   = state_r;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: directed stimulus, a phase/countdown model of
// the sequencer compared on every falling edge, and literal cycle checks.
module tb_clk_rst_sequencer;

  localparam int SETTLE = 8;
  localparam int HOLD   = 4;
  localparam int DEB    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       btn = 1'b0;
  logic       clk_ce;
  logic       rst_out;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .RST_HOLD_CYCLES(HOLD),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .btn          (btn),
    .clk_ce       (clk_ce),
    .rst_out      (rst_out),
    .ready        (ready),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_SETTLE, PH_ON, PH_RUN, PH_FAULT} ph_t;

  ph_t m_ph;
  int  m_remain;
  int  m_llc;
  bit  m_press;
  bit  m_db;
  int  m_run;
  bit  lock_q[$];
  bit  btn_q[$];

  function automatic int ph_code(input ph_t p);
    case (p)
      PH_SETTLE: return 1;
      PH_ON:     return 2;
      PH_RUN:    return 3;
      PH_FAULT:  return 4;
      default:   return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE;
    m_remain = 0;
    m_llc = 0;
    m_press = 1'b0;
    m_db = 1'b0;
    m_run = 0;
    lock_q.delete();
    btn_q.delete();
    repeat (2) begin
      lock_q.push_back(1'b0);
      btn_q.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit ls;
    bit bs;
    bit pr;
    ls = lock_q.pop_front();
    lock_q.push_back(locked);
    bs = btn_q.pop_front();
    btn_q.push_back(btn);
    pr = m_press;
    m_press = 1'b0;
    case (m_ph)
      PH_IDLE: if (ls) begin
        m_ph = PH_SETTLE;
        m_remain = SETTLE;
      end
      PH_SETTLE: if (!ls) m_ph = PH_IDLE;
      else begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          m_ph = PH_ON;
          m_remain = HOLD;
        end
      end
      PH_ON: if (!ls) m_ph = PH_FAULT;
      else begin
        m_remain = m_remain - 1;
        if (m_remain == 0) m_ph = PH_RUN;
      end
      PH_RUN: if (!ls) begin
        m_ph = PH_FAULT;
        if (m_llc < 255) m_llc = m_llc + 1;
      end else if (pr) begin
        m_ph = PH_ON;
        m_remain = HOLD;
      end
      default: m_ph = PH_IDLE;
    endcase
    if (bs != m_db) begin
      m_run = m_run + 1;
      if (m_run == DEB) begin
        m_db = bs;
        m_run = 0;
        if (bs) m_press = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("m_state", int'(state), ph_code(m_ph));
      check("m_clk_ce", int'(clk_ce), int'(m_ph == PH_ON || m_ph == PH_RUN));
      check("m_rst_out", int'(rst_out), int'(m_ph != PH_RUN));
      check("m_ready", int'(ready), int'(m_ph == PH_RUN));
      check("m_llc", int'(lock_loss_cnt), m_llc);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_run(input string name);
    for (int i = 0; i < 40 && state != 3'd3; i++) tick(1);
    check(name, int'(state), 3);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_llc;
    tick(3);
    check("rst_state", int'(state), 0);
    check("rst_clk_ce", int'(clk_ce), 0);
    check("rst_rst_out", int'(rst_out), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_llc", int'(lock_loss_cnt), 0);

    // Cold start: locked rises at cycle 10 after release.
    rst = 1'b0;
    tick(10);
    locked = 1'b1;
    tick(2);
    check("cold_c12_state", int'(state), 0);
    tick(1);
    check("cold_c13_state", int'(state), 1);
    tick(7);
    check("cold_c20_clk_ce", int'(clk_ce), 0);
    tick(1);
    check("cold_c21_clk_ce", int'(clk_ce), 1);
    check("cold_c21_state", int'(state), 2);
    tick(3);
    check("cold_c24_rst_out", int'(rst_out), 1);
    tick(1);
    check("cold_c25_rst_out", int'(rst_out), 0);
    check("cold_c25_ready", int'(ready), 1);
    check("cold_c25_llc", int'(lock_loss_cnt), 0);

    // Short button glitch: never accepted.
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(30);
    check("glitch_state", int'(state), 3);

    // Held button: press at cycle 18, soft reset for HOLD cycles.
    btn = 1'b1;
    tick(18);
    check("btn_c18_state", int'(state), 3);
    tick(1);
    check("btn_c19_state", int'(state), 2);
    check("btn_c19_rst_out", int'(rst_out), 1);
    check("btn_c19_clk_ce", int'(clk_ce), 1);
    tick(3);
    check("btn_c22_state", int'(state), 2);
    check("btn_c22_clk_ce", int'(clk_ce), 1);
    tick(1);
    check("btn_c23_state", int'(state), 3);
    tick(7);
    btn = 1'b0;
    tick(30);
    check("btn_after_state", int'(state), 3);

    // Press and lock loss land on the same edge: lock loss wins.
    btn = 1'b1;
    tick(16);
    locked = 1'b0;
    tick(2);
    check("sim_c18_state", int'(state), 3);
    tick(1);
    check("sim_c19_state", int'(state), 4);
    check("sim_c19_llc", int'(lock_loss_cnt), 1);
    check("sim_c19_clk_ce", int'(clk_ce), 0);
    tick(1);
    check("sim_c20_state", int'(state), 0);
    btn = 1'b0;
    tick(25);

    // Repeated lock loss in RUN: counter saturates at 255.
    exp_llc = 1;
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b1;
      wait_run("loss_reach_run");
      locked = 1'b0;
      tick(2);
      check("loss_c2_clk_ce", int'(clk_ce), 1);
      tick(1);
      check("loss_c3_clk_ce", int'(clk_ce), 0);
      check("loss_c3_rst_out", int'(rst_out), 1);
      if (exp_llc < 255) exp_llc = exp_llc + 1;
      tick(1);
      check("loss_c4_state", int'(state), 0);
      check("loss_c4_llc", int'(lock_loss_cnt), exp_llc);
    end
    check("loss_saturated", int'(lock_loss_cnt), 255);
    tick(2);

    // Lock bounce during settle, then a full settle again.
    locked = 1'b1;
    tick(3);
    check("bounce_c3_state", int'(state), 1);
    tick(2);
    locked = 1'b0;
    tick(3);
    check("bounce_back_state", int'(state), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bounce_clk_ce", int'(clk_ce), 0);
    end
    locked = 1'b1;
    tick(3);
    check("resettle_c3_state", int'(state), 1);
    tick(7);
    check("resettle_c10_clk_ce", int'(clk_ce), 0);
    tick(1);
    check("resettle_c11_clk_ce", int'(clk_ce), 1);

    // Asynchronous reset between clock edges while in CLK_ON.
    tick(1);
    check("arst_pre_state", int'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_clk_ce", int'(clk_ce), 0);
    check("arst_rst_out", int'(rst_out), 1);
    check("arst_ready", int'(ready), 0);
    check("arst_llc", int'(lock_loss_cnt), 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("arst_rel_c2_state", int'(state), 0);
    tick(1);
    check("arst_rel_c3_state", int'(state), 1);
    wait_run("arst_reach_run");
    check("arst_final_ready", int'(ready), 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    errors = errors + 1;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
